// File: rtl/jfive_mmio_console.sv
// jfive console: three-register MMIO window, a byte FIFO, and an 8N1 LSB-first
// serial transmitter whose bit time is divider+1 clocks.
module jfive_mmio_console #(
  parameter logic [15:0]          BASE_ADDR      = 16'h0100,
  parameter int                   FIFO_PTR_WIDTH = 4,
  parameter int                   DIV_WIDTH      = 16,
  parameter logic [DIV_WIDTH-1:0] DIV_INIT       = 16'd867
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic [15:0] mmio_addr,
  input  logic [3:0]  mmio_sel,
  input  logic [31:0] mmio_wdata,
  output logic [31:0] mmio_rdata,
  output logic        uart_tx,
  output logic        tx_busy
);

  localparam int DEPTH = 2 ** FIFO_PTR_WIDTH;
  localparam int CW    = FIFO_PTR_WIDTH + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_e;

  state_e                    state_q;
  logic [7:0]                shreg_q;
  logic [DIV_WIDTH-1:0]      div_q, bcnt_q;
  logic [2:0]                cnt_q;
  logic                      tx_q, tx_busy_q;

  logic [7:0]                mem_q [DEPTH];
  logic [FIFO_PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]             count_q, count_d;
  logic                      ovf_q, ovf_d;
  logic [DIV_WIDTH-1:0]      divider_q, divider_d;
  logic [31:0]               rdata_q, rdata_d;

  logic                      hit, push_req, push, pop, empty, full, ovf_clr, div_wr;
  logic [1:0]                off;
  logic [31:0]               div_ext, div_merge, status;

  assign hit      = (mmio_addr[15:4] == BASE_ADDR[15:4]);
  assign off      = mmio_addr[3:2];
  assign push_req = mmio_wr && hit && (off == 2'd0) && mmio_sel[0];
  assign ovf_clr  = mmio_wr && hit && (off == 2'd1) && mmio_sel[0] && mmio_wdata[3];
  assign div_wr   = mmio_wr && hit && (off == 2'd2);

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = (state_q == ST_IDLE) && !empty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push  = push_req && (!full || pop);

  assign div_ext = 32'(divider_q);
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign div_merge[gi*8 +: 8] = mmio_sel[gi] ? mmio_wdata[gi*8 +: 8] : div_ext[gi*8 +: 8];
  end

  assign status = {16'h0, 8'(count_q), 4'h0, ovf_q, empty, full, tx_busy_q};

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q;
    if (ovf_clr)             ovf_d = 1'b0;
    if (push_req && !push)   ovf_d = 1'b1;
    divider_d = div_wr ? div_merge[DIV_WIDTH-1:0] : divider_q;
    rdata_d = rdata_q;
    if (mmio_rd) begin
      rdata_d = '0;
      if (hit) begin
        case (off)
          2'd1:    rdata_d = status;
          2'd2:    rdata_d = div_ext;
          default: rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= mmio_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      divider_q <= DIV_INIT;
      rdata_q   <= '0;
      tx_busy_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      divider_q <= divider_d;
      rdata_q   <= rdata_d;
      tx_busy_q <= !empty || (state_q != ST_IDLE);
    end
  end

  // Every state holds for div_q+1 clocks; div_q is frozen for the whole frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      div_q   <= '0;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shreg_q <= mem_q[rd_ptr_q];
            div_q   <= divider_q;
            bcnt_q  <= '0;
            tx_q    <= 1'b0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (bcnt_q == div_q) begin
            bcnt_q  <= '0;
            cnt_q   <= '0;
            tx_q    <= shreg_q[0];
            state_q <= ST_DATA;
          end else begin
            bcnt_q <= bcnt_q + DIV_WIDTH'(1);
          end
        end
        ST_DATA: begin
          if (bcnt_q == div_q) begin
            bcnt_q <= '0;
            if (cnt_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              cnt_q   <= cnt_q + 3'd1;
              shreg_q <= {1'b0, shreg_q[7:1]};
              tx_q    <= shreg_q[1];
            end
          end else begin
            bcnt_q <= bcnt_q + DIV_WIDTH'(1);
          end
        end
        default: begin
          tx_q <= 1'b1;
          if (bcnt_q == div_q) begin
            bcnt_q  <= '0;
            state_q <= ST_IDLE;
          end else begin
            bcnt_q <= bcnt_q + DIV_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign mmio_rdata = rdata_q;
  assign uart_tx    = tx_q;
  assign tx_busy    = tx_busy_q;

  logic unused_ok;
  assign unused_ok = ^{mmio_addr[1:0], div_merge};

endmodule
